dct_quant_zigzag: RTL
=====================

DCT_QUANT_ZIGZAG -- requirements
Module: dct_quant_zigzag

Interface
- REQ-001: FIXED_POINT_LENGTH, default 32: width of each signed DCT coefficient word.
- REQ-002: FRAC_BITS, default 15: fraction bits of each coefficient word.
- REQ-003: QOUT_WIDTH, default 12: width of the signed quantized output.
- REQ-004: clk  input  1  single clock; all logic on the rising edge.
- REQ-005: rst  input  1  synchronous, active-high reset.
- REQ-006: in_valid  input  1  a DCT block is present on the inputs.
- REQ-007: in_ready  output  1  block can be accepted.
- REQ-008: dct_y_in, dct_cb_in, dct_cr_in  input  64*FIXED_POINT_LENGTH each  coefficient i = row*8+col at bits [i*FIXED_POINT_LENGTH +: FIXED_POINT_LENGTH], natural order.
- REQ-009: out_valid  output  1  the output coefficient is valid.
- REQ-010: out_ready  input  1  the sink accepts the output coefficient.
- REQ-011: out_coef  output  QOUT_WIDTH  signed quantized coefficient.
- REQ-012: out_comp  output  2  0=Y, 1=Cb, 2=Cr.
- REQ-013: out_zz  output  6  zigzag position 0..63.
- REQ-014: out_last  output  1  asserted with the final coefficient (Cr, zz 63).

Function
- REQ-015: The FSM SHALL have two states: IDLE and EMIT; in_ready = 1 exactly in IDLE with rst low.
- REQ-016: In IDLE, an in_valid && in_ready handshake SHALL register all 192 coefficients, set comp=0 and zz=0, and enter EMIT.
- REQ-017: out_valid SHALL rise on the first clock edge after the input handshake (latency 1 cycle).
- REQ-018: Emission order SHALL be all 64 Y coefficients in JPEG zigzag order, then all 64 Cb, then all 64 Cr.
- REQ-019: Zigzag position k SHALL select natural index ZZ[k] from the standard JPEG table (ZZ[0]=0, ZZ[1]=1, ZZ[2]=8, ZZ[3]=16, ..., ZZ[63]=63).
- REQ-020: Y SHALL use the JPEG Annex K luma table and Cb/Cr the chroma table (quality 50), both indexed by natural index.
- REQ-021: The reciprocal constant R = round(65536/Q) SHALL be stored per table entry.
- REQ-022: Arithmetic: p = coef*R (full-precision signed), S = FRAC_BITS+16, q = sign(p)*floor((|p| + 2^(S-1)) / 2^S).
- REQ-023: q SHALL saturate to [-2^(QOUT_WIDTH-1), 2^(QOUT_WIDTH-1)-1].
- REQ-024: While out_valid && !out_ready, out_coef, out_comp, out_zz and out_last SHALL hold stable.
- REQ-025: Each out_valid && out_ready handshake SHALL advance to the next position, wrapping zz 63->0 and incrementing comp, with the next value presented on the following edge.
- REQ-026: With out_ready held high, a new coefficient SHALL appear every cycle, giving 192 output cycles per block.
- REQ-027: The handshake with out_last=1 SHALL drop out_valid, return to IDLE, and raise in_ready on the next cycle, so throughput with no stalls is 193 cycles per block.
- REQ-028: in_valid asserted during EMIT SHALL be ignored, and the input buffer SHALL be unchanged.

Reset
- REQ-029: With rst high, the block SHALL set state=IDLE, in_ready=0, out_valid=0, out_coef=0, out_comp=0, out_zz=0 and out_last=0.
- REQ-030: Reset asserted mid-block SHALL discard the remaining coefficients; in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
- REQ-031: All-zero block, out_ready=1 -> 192 outputs equal to 0, in_ready=0 during them, out_last only on comp=2 zz=63, in_ready=1 one cycle later.
- REQ-032: Y[0]=1024.0 (0x02000000), Y[1]=110.0, Y[8]=-8.5, rest 0 -> Y zz0=64, zz1=10, zz2=-1, other Y outputs 0.
- REQ-033: Cb[0]=65000.0 and Cr[0]=-65000.0 -> Cb zz0=2047 and Cr zz0=-2048 (saturated).
- REQ-034: out_ready random 50% duty -> outputs stable while stalled and sequence identical to REQ-032.
- REQ-035: rst pulsed for 1 cycle at output 100, then a new block -> out_valid=0 the cycle after rst, new block emitted from Y zz0 with correct values.
- REQ-036: in_valid held high with a different block during EMIT -> first block's 192 outputs unaffected; second block accepted in the cycle after out_last.

Source files
------------

// File: rtl/dct_quant_zigzag_if.sv
// Block-in / coefficient-out bundle for dct_quant_zigzag.
// The slave modport is the quantizer's view; master is the producer/consumer side.
interface dct_quant_zigzag_if #(
  parameter int unsigned FIXED_POINT_LENGTH = 32,
  parameter int unsigned QOUT_WIDTH         = 12
);
  logic                            in_valid;
  logic                            in_ready;
  logic [64*FIXED_POINT_LENGTH-1:0] dct_y_in;
  logic [64*FIXED_POINT_LENGTH-1:0] dct_cb_in;
  logic [64*FIXED_POINT_LENGTH-1:0] dct_cr_in;
  logic                            out_valid;
  logic                            out_ready;
  logic [QOUT_WIDTH-1:0]           out_coef;
  logic [1:0]                      out_comp;
  logic [5:0]                      out_zz;
  logic                            out_last;

  modport master (
    output in_valid, dct_y_in, dct_cb_in, dct_cr_in, out_ready,
    input  in_ready, out_valid, out_coef, out_comp, out_zz, out_last
  );

  modport slave (
    input  in_valid, dct_y_in, dct_cb_in, dct_cr_in, out_ready,
    output in_ready, out_valid, out_coef, out_comp, out_zz, out_last
  );
endinterface

// File: rtl/dct_quant_zigzag.sv
// Buffers one Y/Cb/Cr DCT block, then streams 192 quantized coefficients in JPEG zigzag
// order (Y, Cb, Cr) using per-entry reciprocal multiplication with round-half-away rounding.
module dct_quant_zigzag #(
  parameter int unsigned FIXED_POINT_LENGTH = 32,
  parameter int unsigned FRAC_BITS          = 15,
  parameter int unsigned QOUT_WIDTH         = 12
) (
  input  logic              clk,
  input  logic              rst,
  dct_quant_zigzag_if.slave bus
);
  localparam int unsigned Fpl   = FIXED_POINT_LENGTH;
  localparam int unsigned BusW  = 64 * Fpl;
  localparam int unsigned ProdW = Fpl + 18;
  localparam int unsigned Shift = FRAC_BITS + 16;

  localparam int ZigZag [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam int QLuma [64] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };

  localparam int QChroma [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99
  };

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  // Constant lookup tables; R = round(65536/Q) is folded at elaboration.
  logic [63:0][5:0]  zz_map;
  logic [63:0][16:0] r_luma;
  logic [63:0][16:0] r_chroma;

  for (genvar i = 0; i < 64; i++) begin : g_tab
    assign zz_map[i]   = 6'(ZigZag[i]);
    assign r_luma[i]   = 17'((65536 + QLuma[i] / 2) / QLuma[i]);
    assign r_chroma[i] = 17'((65536 + QChroma[i] / 2) / QChroma[i]);
  end

  state_e                        state_q, state_d;
  logic [BusW-1:0]               buf_y_q, buf_cb_q, buf_cr_q;
  logic [1:0]                    comp_q, comp_d;
  logic [5:0]                    zz_q, zz_d;
  logic                          valid_q, valid_d;
  logic                          last_q, last_d;
  logic signed [QOUT_WIDTH-1:0]  coef_q, coef_d;

  logic                          in_ready;
  logic                          accept;
  logic                          advance;

  assign in_ready = (state_q == StIdle) && !rst;
  assign accept   = bus.in_valid && in_ready;
  assign advance  = (state_q == StEmit) && valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    comp_d  = comp_q;
    zz_d    = zz_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept) begin
      state_d = StEmit;
      comp_d  = 2'd0;
      zz_d    = 6'd0;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (advance) begin
      if (last_q) begin
        state_d = StIdle;
        comp_d  = 2'd0;
        zz_d    = 6'd0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        zz_d   = zz_q + 6'd1;
        comp_d = (zz_q == 6'd63) ? comp_q + 2'd1 : comp_q;
        last_d = (comp_d == 2'd2) && (zz_d == 6'd63);
      end
    end
  end

  // Quantize the coefficient for the next position; on acceptance read straight from the
  // input bus so the first output is ready one cycle after the handshake.
  logic [5:0]                   nat;
  logic [BusW-1:0]              src;
  logic signed [Fpl-1:0]        word;
  logic [16:0]                  recip;
  logic signed [ProdW-1:0]      prod;
  logic [ProdW-1:0]             mag;
  logic [ProdW-1:0]             rnd;
  logic signed [QOUT_WIDTH-1:0] quant;

  localparam logic [ProdW-1:0] PosLim = ProdW'((64'd1 << (QOUT_WIDTH - 1)) - 64'd1);
  localparam logic [ProdW-1:0] NegLim = ProdW'(64'd1 << (QOUT_WIDTH - 1));

  always_comb begin
    nat = zz_map[zz_d];
    case (comp_d)
      2'd0:    src = accept ? bus.dct_y_in  : buf_y_q;
      2'd1:    src = accept ? bus.dct_cb_in : buf_cb_q;
      default: src = accept ? bus.dct_cr_in : buf_cr_q;
    endcase
    word  = src[nat*Fpl +: Fpl];
    recip = (comp_d == 2'd0) ? r_luma[nat] : r_chroma[nat];
    prod  = ProdW'(word) * ProdW'($signed({1'b0, recip}));
    mag   = prod[ProdW-1] ? $unsigned(-prod) : $unsigned(prod);
    rnd   = (mag + (ProdW'(1) << (Shift - 1))) >> Shift;
    if (!prod[ProdW-1]) begin
      quant = (rnd > PosLim) ? {1'b0, {(QOUT_WIDTH-1){1'b1}}} : QOUT_WIDTH'(rnd);
    end else begin
      quant = (rnd > NegLim) ? {1'b1, {(QOUT_WIDTH-1){1'b0}}} : QOUT_WIDTH'(-rnd);
    end
    coef_d = coef_q;
    if (accept || advance) begin
      coef_d = valid_d ? quant : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      comp_q  <= 2'd0;
      zz_q    <= 6'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      coef_q  <= '0;
    end else begin
      state_q <= state_d;
      comp_q  <= comp_d;
      zz_q    <= zz_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      coef_q  <= coef_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_y_q  <= bus.dct_y_in;
      buf_cb_q <= bus.dct_cb_in;
      buf_cr_q <= bus.dct_cr_in;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_coef  = coef_q;
  assign bus.out_comp  = comp_q;
  assign bus.out_zz    = zz_q;
  assign bus.out_last  = last_q;
endmodule
